// File: rtl/screen_draw_engine_if.sv
// Draw engine signal bundle: controller request, image ROM port and VGA
// pixel port. The engine uses the slave view; the environment (controller,
// ROM and VGA adapter) uses the master view.
interface screen_draw_engine_if;
  // Controller request
  logic        start;
  logic        spriteMode;
  logic        black;
  logic [4:0]  memorySel;
  logic [7:0]  xOrigin;
  logic [6:0]  yOrigin;
  // Image ROM
  logic [4:0]  romSel;
  logic [14:0] romAddr;
  logic [2:0]  romData;
  // VGA adapter and status
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  modport master (
    output start, spriteMode, black, memorySel, xOrigin, yOrigin, romData,
    input  romSel, romAddr, x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, spriteMode, black, memorySel, xOrigin, yOrigin, romData,
    output romSel, romAddr, x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/screen_draw_engine.sv
// Screen/sprite draw engine. Walks a 160x120 screen or a 40x40 sprite image
// in raster order, reading one colour per cycle from a ROM with one cycle of
// read latency and presenting each pixel to the VGA adapter at its origin
// offset. Off-screen pixels are clipped (still cost a cycle).
// Optional feature macro: DRAW_TRANSPARENT_EN -- ROM colour 3'b101 is not
// plotted (unless the draw is forced black), letting the background show.
module screen_draw_engine (
  input logic                  clk,
  input logic                  drawReset,
  screen_draw_engine_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAW, DONE} state_t;

  state_t      state;
  logic        sprite_q;
  logic        black_q;
  logic [4:0]  sel_q;
  logic [7:0]  xo_q;
  logic [6:0]  yo_q;
  logic [7:0]  col;
  logic [6:0]  row;
  logic [14:0] addr_q;

  logic [7:0]  col_last;
  logic [6:0]  row_last;
  logic [14:0] addr_last;
  logic        last_pixel;
  logic [8:0]  x_true;
  logic [7:0]  y_true;
  logic        in_draw;
  logic        on_screen;
  logic        transparent;

  // Image geometry of the captured draw.
  assign col_last   = sprite_q ? 8'd39     : 8'd159;
  assign row_last   = sprite_q ? 7'd39     : 7'd119;
  assign addr_last  = sprite_q ? 15'd1599  : 15'd19199;
  assign last_pixel = (col == col_last) && (row == row_last);

  // Control FSM with pixel counters and the ROM address register.
  // NOTE: every register here uses non-blocking assignment so all of them
  // update together from the values of the previous cycle.
  always_ff @(posedge clk or posedge drawReset) begin
    if (drawReset) begin
      state    <= IDLE;
      sprite_q <= 1'b0;
      black_q  <= 1'b0;
      sel_q    <= '0;
      xo_q     <= '0;
      yo_q     <= '0;
      col      <= '0;
      row      <= '0;
      addr_q   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          addr_q <= '0;
          if (bus.start) begin
            sprite_q <= bus.spriteMode;
            black_q  <= bus.black;
            sel_q    <= bus.memorySel;
            xo_q     <= bus.xOrigin;
            yo_q     <= bus.yOrigin;
            state    <= FETCH;
          end else begin
            state <= IDLE;
          end
        end
        FETCH: begin
          col    <= '0;
          row    <= '0;
          addr_q <= 15'd1;
          state  <= DRAW;
        end
        DRAW: begin
          if (last_pixel) begin
            addr_q <= '0;
            state  <= DONE;
          end else begin
            if (col == col_last) begin
              col <= '0;
              row <= row + 7'd1;
            end else begin
              col <= col + 8'd1;
            end
            // The address runs one pixel ahead and parks on the last pixel.
            if (addr_q != addr_last) addr_q <= addr_q + 15'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Untruncated screen position decides clipping; outputs are truncated.
  assign x_true    = {1'b0, xo_q} + {1'b0, col};
  assign y_true    = {1'b0, yo_q} + {1'b0, row};
  assign in_draw   = (state == DRAW);
  assign on_screen = (x_true < 9'd160) && (y_true < 8'd120);

`ifdef DRAW_TRANSPARENT_EN
  assign transparent = !black_q && (bus.romData == 3'b101);
`else
  assign transparent = 1'b0;
`endif

  // Output decode: everything except busy/done/romSel is zero outside DRAW.
  assign bus.x       = in_draw ? x_true[7:0] : 8'd0;
  assign bus.y       = in_draw ? y_true[6:0] : 7'd0;
  assign bus.colour  = (in_draw && !black_q) ? bus.romData : 3'b000;
  assign bus.plot    = in_draw && on_screen && !transparent;
  assign bus.busy    = (state == FETCH) || (state == DRAW);
  assign bus.done    = (state == DONE);
  assign bus.romAddr = addr_q;
  assign bus.romSel  = sel_q;

endmodule

// File: tb/tb_screen_draw_engine.sv
// Self-checking bench for screen_draw_engine: a table of directed draws,
// randomized sprite draws and hand-written reset sequences, all compared
// against a per-pixel reference model computed from the draw rules.
module tb_screen_draw_engine;

  logic clk = 1'b0;
  logic drawReset;
  int   checks   = 0;
  int   failures = 0;
  int   rom_mode = 0;

  localparam bit TRANSP_EN =
`ifdef DRAW_TRANSPARENT_EN
    1'b1;
`else
    1'b0;
`endif

  always #5 clk = ~clk;

  screen_draw_engine_if bus();

  screen_draw_engine dut (
    .clk       (clk),
    .drawReset (drawReset),
    .bus       (bus.slave)
  );

  // Image ROM contents for the different test patterns.
  function automatic logic [2:0] rom_fn(input int mode, input logic [14:0] a,
                                        input logic [4:0] sel);
    case (mode)
      0:       return a[2:0];
      1:       return a[0] ? 3'b011 : 3'b101;
      default: return a[2:0] ^ a[9:7] ^ sel[2:0];
    endcase
  endfunction

  // ROM with one cycle of read latency.
  always @(posedge clk) bus.romData <= rom_fn(rom_mode, bus.romAddr, bus.romSel);

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  typedef struct {
    bit         sprite;
    bit         blk;
    logic [4:0] sel;
    logic [7:0] xo;
    logic [6:0] yo;
    int         mode;
    int         extra_start;  // cycle of an ignored second start, 0 = none
    int         exp_plots;    // -1 = take the count from the model only
    int         exp_done;
  } vec_t;

  // Run one draw from its start pulse to one cycle past done, comparing
  // every cycle against the model.
  task automatic run_draw(input vec_t v);
    int n, w, k, col, row, tx, ty, ec, errs;
    int plots, mplots, done_cnt, done_cyc;
    int afirst, alx, aly, alc, mfirst, mlx, mly, mlc;
    logic [2:0] rc;
    bit vis, exp_busy, exp_done;
    n = v.sprite ? 1600 : 19200;
    w = v.sprite ? 40 : 160;
    errs = 0; plots = 0; mplots = 0; done_cnt = 0; done_cyc = -1;
    afirst = -1; alx = -1; aly = -1; alc = -1;
    mfirst = -1; mlx = -1; mly = -1; mlc = -1;
    rom_mode = v.mode;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.spriteMode = v.sprite;
    bus.black      = v.blk;
    bus.memorySel  = v.sel;
    bus.xOrigin    = v.xo;
    bus.yOrigin    = v.yo;
    for (int c = 1; c <= n + 3; c++) begin
      @(negedge clk);
      k = c - 2;
      exp_busy = (c <= n + 1);
      exp_done = (c == n + 2);
      if (bus.busy !== exp_busy) errs++;
      if (bus.done !== exp_done) errs++;
      if (bus.done === 1'b1) begin done_cnt++; done_cyc = c; end
      if (bus.plot === 1'b1) begin
        plots++;
        if (afirst < 0) afirst = c;
        alx = bus.x; aly = bus.y; alc = bus.colour;
      end
      if (k >= 0 && k < n) begin
        col = k % w;
        row = k / w;
        tx  = v.xo + col;
        ty  = v.yo + row;
        rc  = rom_fn(v.mode, 15'(k), v.sel);
        ec  = v.blk ? 0 : rc;
        vis = (tx < 160) && (ty < 120) && !(TRANSP_EN && !v.blk && rc == 3'b101);
        if (vis) begin
          mplots++;
          if (mfirst < 0) mfirst = c;
          mlx = tx % 256; mly = ty % 128; mlc = ec;
        end
        if (bus.plot !== vis) errs++;
        if (bus.colour !== 3'(ec)) errs++;
        if (bus.x !== 8'(tx % 256)) errs++;
        if (bus.y !== 7'(ty % 128)) errs++;
        if (bus.romAddr !== 15'((k == n - 1) ? n - 1 : k + 1)) errs++;
      end else if (c == 1) begin
        if (bus.romAddr !== 15'd0 || bus.plot !== 1'b0) errs++;
      end else begin
        if (bus.plot !== 1'b0) errs++;
        if (c == n + 3 && (bus.x !== 8'd0 || bus.y !== 7'd0 || bus.colour !== 3'd0
                           || bus.romAddr !== 15'd0)) errs++;
      end
      // Scramble request inputs so a wrongly re-captured value shows up.
      bus.start      = (c == v.extra_start);
      bus.spriteMode = 1'($urandom);
      bus.black      = 1'($urandom);
      bus.memorySel  = 5'($urandom);
      bus.xOrigin    = 8'($urandom);
      bus.yOrigin    = 7'($urandom);
    end
    bus.start = 1'b0;
    check("cycle_stream_errors", errs, 0);
    check("plot_count_vs_model", plots, mplots);
    if (v.exp_plots >= 0) check("plot_count_vs_table", plots, v.exp_plots);
    check("done_pulses", done_cnt, 1);
    check("done_cycle", done_cyc, v.exp_done);
    check("first_plot_cycle", afirst, mfirst);
    check("last_plot_x", alx, mlx);
    check("last_plot_y", aly, mly);
    check("last_plot_colour", alc, mlc);
    check("rom_sel_captured", bus.romSel, v.sel);
  endtask

  task automatic check_idle(input string name);
    check({name, "_x"}, bus.x, 0);
    check({name, "_y"}, bus.y, 0);
    check({name, "_colour"}, bus.colour, 0);
    check({name, "_plot"}, bus.plot, 0);
    check({name, "_busy"}, bus.busy, 0);
    check({name, "_done"}, bus.done, 0);
    check({name, "_romaddr"}, bus.romAddr, 0);
  endtask

  vec_t vecs[5];

  initial begin
    int errs;
    vec_t rv;
    vecs[0] = '{1'b0, 1'b0, 5'd3,  8'd0,   7'd0,   0, 0,    19200, 19202};
    vecs[1] = '{1'b1, 1'b0, 5'd7,  8'd60,  7'd40,  0, 0,    1600,  1602};
    vecs[2] = '{1'b1, 1'b0, 5'd9,  8'd140, 7'd100, 0, 0,    400,   1602};
    vecs[3] = '{1'b0, 1'b1, 5'd1,  8'd0,   7'd0,   0, 5000, 19200, 19202};
    vecs[4] = '{1'b1, 1'b0, 5'd2,  8'd10,  7'd10,  1, 0,    TRANSP_EN ? 800 : 1600, 1602};

    drawReset      = 1'b1;
    bus.start      = 1'b0;
    bus.spriteMode = 1'b1;
    bus.black      = 1'b1;
    bus.memorySel  = 5'h1f;
    bus.xOrigin    = 8'hff;
    bus.yOrigin    = 7'h7f;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_romsel", bus.romSel, 0);
    drawReset = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("idle_after_reset");

    foreach (vecs[i]) run_draw(vecs[i]);

    // Randomized sprite draws with an ignored mid-draw start.
    for (int r = 0; r < 6; r++) begin
      rv.sprite      = 1'b1;
      rv.blk         = 1'($urandom);
      rv.sel         = 5'($urandom);
      rv.xo          = 8'($urandom_range(255, 0));
      rv.yo          = 7'($urandom_range(127, 0));
      rv.mode        = 2;
      rv.extra_start = $urandom_range(1601, 1);
      rv.exp_plots   = -1;
      rv.exp_done    = 1602;
      run_draw(rv);
    end

    // Reset abort at cycle 500 of a screen draw.
    rom_mode = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.spriteMode = 1'b0; bus.black = 1'b0;
    bus.memorySel = 5'd4; bus.xOrigin = 8'd0; bus.yOrigin = 7'd0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 2; c <= 500; c++) @(negedge clk);
    check("pre_abort_busy", bus.busy, 1);
    check("pre_abort_plot", bus.plot, 1);
    drawReset = 1'b1;
    #1;
    check_idle("abort");
    check("abort_romsel", bus.romSel, 0);
    @(negedge clk);
    drawReset = 1'b0;
    errs = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.plot !== 1'b0) errs++;
    end
    check("stays_idle_after_abort", errs, 0);

    // Start sampled on the same edge that follows reset release is accepted.
    drawReset = 1'b1;
    @(negedge clk);
    drawReset = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_at_release_busy", bus.busy, 1);
    check("start_at_release_fetch_addr", bus.romAddr, 0);
    check("start_at_release_plot", bus.plot, 0);
    drawReset = 1'b1;
    @(negedge clk);
    drawReset = 1'b0;
    @(negedge clk);
    check_idle("second_abort");

    // Full redraw after the aborts.
    run_draw(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
